// File: rtl/dmem_responder.sv
// Data-memory target for the CPU load/store port: req/ack handshake with wait
// states, byte-lane stores, alignment/range errors and a sticky MMIO done flag.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] DONE_ADDR   = 32'hFFFF_FFF0,
  parameter logic [31:0] PASS_VALUE  = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        MemAck,
  output logic        MemErr,
  output logic        SimDone,
  output logic        SimPass,
  output logic [15:0] WriteCount
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q;
  logic [31:0] adr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        ack_q, err_q, done_q, pass_q;
  logic [15:0] wcnt_q;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (MemReq) begin
        cnt_d   = WS;
        state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is also the capture edge, so the
  // live inputs stand in for the not-yet-latched copy.
  logic        eff_wr;
  logic [31:0] eff_adr, eff_wdata;
  logic [3:0]  eff_be;
  logic        commit, is_done, acc_err;
  logic [AW-1:0] idx;

  always_comb begin
    eff_wr    = (state_q == S_IDLE) ? MemWrite  : wr_q;
    eff_adr   = (state_q == S_IDLE) ? DataAdr   : adr_q;
    eff_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
    eff_be    = (state_q == S_IDLE) ? ByteEn    : be_q;
    commit    = reset && (state_d == S_RESP);
    is_done   = (eff_adr == DONE_ADDR);
    acc_err   = !is_done && ((eff_adr[1:0] != 2'b00) || (eff_adr >= LIMIT));
    idx       = eff_adr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (commit && eff_wr && !acc_err && !is_done) begin
      for (int i = 0; i < 4; i++)
        if (eff_be[i]) mem[idx][8*i +: 8] <= eff_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && MemReq) begin
        wr_q    <= MemWrite;
        adr_q   <= DataAdr;
        wdata_q <= WriteData;
        be_q    <= ByteEn;
      end
      ack_q <= commit;
      err_q <= commit && acc_err;
      if (commit) begin
        if (acc_err)
          rdata_q <= '0;
        else if (!eff_wr)
          rdata_q <= is_done ? {30'b0, pass_q, done_q} : mem[idx];
        else if (is_done) begin
          // Only the first DONE write decides pass/fail.
          if (!done_q) begin
            done_q <= 1'b1;
            pass_q <= (eff_wdata == PASS_VALUE);
          end
        end else if (wcnt_q != 16'hFFFF)
          wcnt_q <= wcnt_q + 16'd1;
      end
    end
  end

  assign ReadData   = rdata_q;
  assign MemAck     = ack_q;
  assign MemErr     = err_q;
  assign SimDone    = done_q;
  assign SimPass    = pass_q;
  assign WriteCount = wcnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand sequences for reset,
// done flag and back-to-back acks, then random traffic against a word-array model.
module tb_dmem_responder;

  localparam logic [31:0] DONE = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u_a: one wait state; u_b: zero wait states
  logic        req_a, wr_a, ack_a, err_a, done_a, pass_a;
  logic [31:0] adr_a, wd_a, rd_a;
  logic [3:0]  be_a;
  logic [15:0] wc_a;
  logic        req_b, wr_b, ack_b, err_b, done_b, pass_b;
  logic [31:0] adr_b, wd_b, rd_b;
  logic [3:0]  be_b;
  logic [15:0] wc_b;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) u_a (
    .clk(clk), .reset(reset), .MemReq(req_a), .MemWrite(wr_a), .DataAdr(adr_a),
    .WriteData(wd_a), .ByteEn(be_a), .ReadData(rd_a), .MemAck(ack_a), .MemErr(err_a),
    .SimDone(done_a), .SimPass(pass_a), .WriteCount(wc_a));

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_b (
    .clk(clk), .reset(reset), .MemReq(req_b), .MemWrite(wr_b), .DataAdr(adr_b),
    .WriteData(wd_b), .ByteEn(be_b), .ReadData(rd_b), .MemAck(ack_b), .MemErr(err_b),
    .SimDone(done_b), .SimPass(pass_b), .WriteCount(wc_b));

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: word array plus flags, derived from the access rules.
  logic [31:0] m_mem [64];
  logic [31:0] m_rd = '0;
  logic        m_err, m_done = 1'b0, m_pass = 1'b0;
  int          m_wc = 0;

  task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    m_err = (a != DONE) && ((a % 4 != 0) || (a >= 4 * 64));
    if (m_err) m_rd = '0;
    else if (!wr) m_rd = (a == DONE) ? {30'b0, m_pass, m_done} : m_mem[a / 4];
    else if (a == DONE) begin
      if (!m_done) begin m_done = 1'b1; m_pass = (wd == 32'd1); end
    end else begin
      for (int i = 0; i < 4; i++)
        if (be[i]) m_mem[a / 4][8*i +: 8] = wd[8*i +: 8];
      m_wc = (m_wc < 65535) ? m_wc + 1 : 65535;
    end
  endtask

  // One handshake; starts and ends on a negedge with the target idle.
  task automatic xfer(input bit b, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rd, output logic err,
                      output int lat);
    if (b) begin req_b = 1; wr_b = wr; adr_b = a; wd_b = wd; be_b = be; end
    else   begin req_a = 1; wr_a = wr; adr_a = a; wd_a = wd; be_a = be; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!b && lat == 1 && !ack_a) begin
        adr_a = $urandom; wd_a = $urandom; wr_a = ~wr; be_a = ~be;
      end
    end while (!(b ? ack_b : ack_a) && lat < 20);
    rd  = b ? rd_b : rd_a;
    err = b ? err_b : err_a;
    if (b) req_b = 0; else req_a = 0;
    @(negedge clk);
    chk("ack_one_cycle", b ? ack_b : ack_a, 0);
  endtask

  task automatic apply(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic err,
                       output int lat);
    xfer(0, wr, a, wd, be, rd, err, lat);
    model(wr, a, wd, be);
  endtask

  task automatic rcheck(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] rd; logic err; int lat;
    apply(wr, a, wd, be, rd, err, lat);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_rd"}, rd, m_rd);
    chk({tag, "_wc"}, wc_a, m_wc);
    chk({tag, "_done"}, done_a, m_done);
    chk({tag, "_pass"}, pass_a, m_pass);
  endtask

  typedef struct {
    logic wr; logic [31:0] a; logic [31:0] wd; logic [3:0] be;
    logic chk_rd; logic [31:0] rd; logic err; logic [15:0] wc;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    logic [31:0] rd, a;
    logic err;
    int lat;
    bit seen;

    reset = 0;
    {req_a, wr_a, adr_a, wd_a, be_a} = '0;
    {req_b, wr_b, adr_b, wd_b, be_b} = '0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst_ack", ack_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_wc", wc_a, 0);

    // Abandon a store captured into WAIT
    req_a = 1; wr_a = 1; adr_a = 32'd40; wd_a = 32'h55; be_a = 4'hF;
    @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
    req_a = 0;
    reset = 1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (ack_a) seen = 1; end
    chk("abandon_no_ack", seen, 0);
    chk("abandon_wc", wc_a, 0);
    chk("abandon_done", done_a, 0);

    //             wr  addr     wdata          be      chk rd             err wc
    tv.push_back('{1, 32'd20,  32'hDEADBEEF, 4'hF,   0, 32'h0,          0, 16'd1});
    tv.push_back('{0, 32'd20,  32'h0,        4'h0,   1, 32'hDEADBEEF,   0, 16'd1});
    tv.push_back('{1, 32'd20,  32'h00000002, 4'b0001,0, 32'h0,          0, 16'd2});
    tv.push_back('{0, 32'd20,  32'h0,        4'h0,   1, 32'hDEADBE02,   0, 16'd2});
    tv.push_back('{0, 32'd22,  32'h0,        4'h0,   1, 32'h0,          1, 16'd2});
    tv.push_back('{1, 32'd0,   32'hCAFEF00D, 4'hF,   0, 32'h0,          0, 16'd3});
    tv.push_back('{1, 32'd256, 32'h11111111, 4'hF,   1, 32'h0,          1, 16'd3});
    tv.push_back('{0, 32'd0,   32'h0,        4'h0,   1, 32'hCAFEF00D,   0, 16'd3});
    tv.push_back('{1, 32'd0,   32'hAABBCCDD, 4'h0,   0, 32'h0,          0, 16'd4});
    tv.push_back('{0, 32'd0,   32'h0,        4'h0,   1, 32'hCAFEF00D,   0, 16'd4});
    tv.push_back('{1, 32'd4,   32'hFFFFFFFF, 4'hF,   0, 32'h0,          0, 16'd5});
    tv.push_back('{1, 32'd4,   32'h12345678, 4'b1010,0, 32'h0,          0, 16'd6});
    tv.push_back('{0, 32'd4,   32'h0,        4'h0,   1, 32'h12FF56FF,   0, 16'd6});
    tv.push_back('{1, 32'd7,   32'h0,        4'hF,   1, 32'h0,          1, 16'd6});
    tv.push_back('{0, 32'd256, 32'h0,        4'h0,   1, 32'h0,          1, 16'd6});
    tv.push_back('{0, 32'd252, 32'h0,        4'h0,   0, 32'h0,          0, 16'd6});
    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i].wr, tv[i].a, tv[i].wd, tv[i].be, rd, err, lat);
      chk($sformatf("tv%0d_lat", i), lat, 2);
      chk($sformatf("tv%0d_err", i), err, tv[i].err);
      chk($sformatf("tv%0d_wc", i), wc_a, tv[i].wc);
      if (tv[i].chk_rd) chk($sformatf("tv%0d_rd", i), rd, tv[i].rd);
    end

    // Done flag: first write decides pass, second is ignored
    apply(1, DONE, 32'd1, 4'hF, rd, err, lat);
    chk("done1_err", err, 0);
    chk("done1_flag", done_a, 1);
    apply(1, DONE, 32'd0, 4'hF, rd, err, lat);
    chk("done2_done", done_a, 1);
    chk("done2_pass", pass_a, 1);
    chk("done_wc", wc_a, 6);
    apply(0, DONE, 32'd0, 4'h0, rd, err, lat);
    chk("done_load", rd, 32'h3);

    for (int w = 0; w < 64; w++) rcheck("init", 1, 32'(w * 4), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        6:       a = {24'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        7:       a = 32'd256 + 32'($urandom_range(0, 1000)) * 4;
        8:       a = DONE;
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, 63)) * 4;
      endcase
      rcheck("rnd", 1'($urandom), a, $urandom, 4'($urandom));
    end

    // Saturation from a preloaded count
    @(negedge clk);
    force u_a.wcnt_q = 16'hFFFD;
    #1 release u_a.wcnt_q;
    m_wc = 65533;
    chk("sat_preload", wc_a, 16'hFFFD);
    for (int k = 0; k < 4; k++) rcheck("sat", 1, 32'd12, $urandom, 4'hF);
    chk("sat_final", wc_a, 16'hFFFF);

    // Zero wait states: single-edge latency, then held request for three loads
    xfer(1, 1, 32'd8, 32'hABCD1234, 4'hF, rd, err, lat);
    chk("ws0_st_lat", lat, 1);
    xfer(1, 0, 32'd8, 32'h0, 4'h0, rd, err, lat);
    chk("ws0_ld_lat", lat, 1);
    chk("ws0_ld_rd", rd, 32'hABCD1234);
    chk("ws0_wc", wc_b, 1);
    req_b = 1; wr_b = 0; adr_b = DONE;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("b2b_ack%0d", k), ack_b, 32'(k % 2));
    end
    chk("b2b_rd", rd_b, 0);
    req_b = 0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (ack_b) seen = 1; end
    chk("b2b_no_extra", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
